// File: rtl/imem_loader_if.sv
// imem_loader_if: load-beat and fetch bus between a program source/CPU and imem_loader
//   slave  (loader side): takes ld_start/ld_valid/ld_data/ld_last and pc/fetch_en,
//                         drives ld_ready/ld_done/ld_err/ld_len/ld_csum and op/op_valid
//   master (source side): the mirror image
interface imem_loader_if #(
   parameter int AW = 6,
   parameter int DW = 16
);
   logic          ld_start;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_last;
   logic          ld_ready;
   logic          ld_done;
   logic          ld_err;
   logic [AW:0]   ld_len;
   logic [DW-1:0] ld_csum;
   logic [AW-1:0] pc;
   logic          fetch_en;
   logic [DW-1:0] op;
   logic          op_valid;

   modport slave (
      input  ld_start, ld_valid, ld_data, ld_last, pc, fetch_en,
      output ld_ready, ld_done, ld_err, ld_len, ld_csum, op, op_valid
   );

   modport master (
      output ld_start, ld_valid, ld_data, ld_last, pc, fetch_en,
      input  ld_ready, ld_done, ld_err, ld_len, ld_csum, op, op_valid
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams a program into a 2**AW-word instruction memory, then serves registered fetches
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : load beats (ld_*), load status (ld_ready/ld_done/ld_err/ld_len/ld_csum),
//                fetch request (pc/fetch_en) and registered result (op/op_valid)
module imem_loader #(
   parameter int            AW      = 6,
   parameter int            DW      = 16,
   parameter logic [DW-1:0] FILL_OP = '0
) (
   input logic           clk,
   input logic           rst_n,
   imem_loader_if.slave  bus
);
   localparam int DEPTH = 2 ** AW;

   typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW:0]   len_q, len_d;
   logic [DW-1:0] csum_q, csum_d;
   logic          err_q, err_d;
   logic          done_q, done_d;
   logic [DW-1:0] op_q, op_d;
   logic          op_valid_q, op_valid_d;
   logic [DW-1:0] mem [DEPTH];
   logic          acc;

   // ld_start wins: a beat in the same cycle is dropped
   assign acc = bus.ld_valid && state_q == LOAD && !bus.ld_start;

   assign bus.ld_ready = state_q == LOAD;
   assign bus.ld_done  = done_q;
   assign bus.ld_err   = err_q;
   assign bus.ld_len   = len_q;
   assign bus.ld_csum  = csum_q;
   assign bus.op       = op_q;
   assign bus.op_valid = op_valid_q;

   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      len_d      = len_q;
      csum_d     = csum_q;
      err_d      = err_q;
      done_d     = 1'b0;
      op_d       = op_q;
      op_valid_d = op_valid_q;
      if (bus.ld_start) begin
         state_d = LOAD;
         wptr_d  = '0;
         len_d   = '0;
         csum_d  = '0;
         err_d   = 1'b0;
      end else if (acc) begin
         wptr_d = wptr_q + 1'b1;
         len_d  = len_q + 1'b1;
         csum_d = csum_q ^ bus.ld_data;
         // last beat, or memory full without a last marker (overflow)
         if (bus.ld_last || &wptr_q) begin
            state_d = RUN;
            done_d  = 1'b1;
            err_d   = !bus.ld_last;
         end
      end
      // fetch decisions use the current state, so a fetch alongside ld_start still sees the old program
      if (state_q != RUN) begin
         op_d       = FILL_OP;
         op_valid_d = 1'b0;
      end else if (bus.fetch_en) begin
         op_d       = ({1'b0, bus.pc} < len_q) ? mem[bus.pc] : FILL_OP;
         op_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         wptr_q     <= '0;
         len_q      <= '0;
         csum_q     <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         op_q       <= FILL_OP;
         op_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         len_q      <= len_d;
         csum_q     <= csum_d;
         err_q      <= err_d;
         done_q     <= done_d;
         op_q       <= op_d;
         op_valid_q <= op_valid_d;
      end
   end

   // storage is never cleared; ld_len gates stale contents to FILL_OP
   always_ff @(posedge clk) begin
      if (rst_n && acc) mem[wptr_q] <= bus.ld_data;
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader with a fetch scoreboard
module tb_imem_loader;
   localparam int            AW   = 6;
   localparam int            DW   = 16;
   localparam logic [DW-1:0] FILL = 16'hDEAD;

   typedef struct packed {
      logic          v;
      logic [DW-1:0] op;
   } fetch_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_fail = 0;
   fetch_t exp_q[$];
   logic [DW-1:0] mdl [64];
   logic [DW-1:0] csum;

   imem_loader_if #(.AW(AW), .DW(DW)) bus ();

   imem_loader #(.AW(AW), .DW(DW), .FILL_OP(FILL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [DW-1:0] d, input logic last);
      bus.ld_valid = 1'b1;
      bus.ld_data  = d;
      bus.ld_last  = last;
      tick();
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
   endtask

   // push expectation on issue, pop and compare once the registered result appears
   task automatic fetch(input string tag, input logic [AW-1:0] a, input logic en, input fetch_t e);
      fetch_t r;
      bus.pc       = a;
      bus.fetch_en = en;
      exp_q.push_back(e);
      tick();
      bus.fetch_en = 1'b0;
      r = exp_q.pop_front();
      check({tag, ".op"}, 32'(bus.op), 32'(r.op));
      check({tag, ".v"}, 32'(bus.op_valid), 32'(r.v));
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.ld_start = 1'b0;
      bus.ld_valid = 1'b0;
      bus.ld_data  = '0;
      bus.ld_last  = 1'b0;
      bus.pc       = '0;
      bus.fetch_en = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst.ready", 32'(bus.ld_ready), 0);
      check("rst.done", 32'(bus.ld_done), 0);
      check("rst.err", 32'(bus.ld_err), 0);
      check("rst.len", 32'(bus.ld_len), 0);
      check("rst.csum", 32'(bus.ld_csum), 0);
      check("rst.op", 32'(bus.op), 32'(FILL));
      check("rst.opv", 32'(bus.op_valid), 0);
      fetch("empty", 6'd0, 1'b1, '{v: 1'b0, op: FILL});

      // three-beat program
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
      check("ld3.ready", 32'(bus.ld_ready), 1);
      check("ld3.len0", 32'(bus.ld_len), 0);
      beat(16'h1111, 1'b0);
      beat(16'h2222, 1'b0);
      check("ld3.done_mid", 32'(bus.ld_done), 0);
      fetch("loadfetch", 6'd0, 1'b1, '{v: 1'b0, op: FILL});
      beat(16'h4444, 1'b1);
      check("ld3.done", 32'(bus.ld_done), 1);
      check("ld3.len", 32'(bus.ld_len), 3);
      check("ld3.csum", 32'(bus.ld_csum), 32'h7777);
      check("ld3.err", 32'(bus.ld_err), 0);
      check("ld3.ready_run", 32'(bus.ld_ready), 0);
      tick();
      check("ld3.done_pulse", 32'(bus.ld_done), 0);
      fetch("f1", 6'd1, 1'b1, '{v: 1'b1, op: 16'h2222});
      fetch("f5", 6'd5, 1'b1, '{v: 1'b1, op: FILL});
      fetch("f0", 6'd0, 1'b1, '{v: 1'b1, op: 16'h1111});
      fetch("f2", 6'd2, 1'b1, '{v: 1'b1, op: 16'h4444});
      fetch("f3", 6'd3, 1'b1, '{v: 1'b1, op: FILL});
      fetch("f1b", 6'd1, 1'b1, '{v: 1'b1, op: 16'h2222});
      fetch("hold", 6'd0, 1'b0, '{v: 1'b1, op: 16'h2222});

      // overflow: 64 beats without a last marker
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
      check("ovf.err_clr", 32'(bus.ld_err), 0);
      csum = '0;
      for (int i = 0; i < 64; i++) begin
         mdl[i] = 16'(i * 16'h0513 + 16'h00A7);
         csum ^= mdl[i];
         if (i == 63) check("ovf.ready63", 32'(bus.ld_ready), 1);
         beat(mdl[i], 1'b0);
         if (i == 62) check("ovf.done62", 32'(bus.ld_done), 0);
      end
      check("ovf.err", 32'(bus.ld_err), 1);
      check("ovf.len", 32'(bus.ld_len), 64);
      check("ovf.done", 32'(bus.ld_done), 1);
      check("ovf.csum", 32'(bus.ld_csum), 32'(csum));
      tick();
      check("ovf.ready", 32'(bus.ld_ready), 0);
      check("ovf.err_hold", 32'(bus.ld_err), 1);
      fetch("ovf.f63", 6'd63, 1'b1, '{v: 1'b1, op: mdl[63]});
      fetch("ovf.f0", 6'd0, 1'b1, '{v: 1'b1, op: mdl[0]});
      fetch("ovf.f17", 6'd17, 1'b1, '{v: 1'b1, op: mdl[17]});

      // ld_start wins over a concurrent beat; fetch in the same cycle sees the old program
      bus.ld_start = 1'b1;
      bus.ld_valid = 1'b1;
      bus.ld_data  = 16'hBEEF;
      fetch("startfetch", 6'd5, 1'b1, '{v: 1'b1, op: mdl[5]});
      bus.ld_start = 1'b0;
      bus.ld_valid = 1'b0;
      check("drop.len", 32'(bus.ld_len), 0);
      check("drop.err", 32'(bus.ld_err), 0);
      beat(16'h0001, 1'b1);
      check("drop.len1", 32'(bus.ld_len), 1);
      check("drop.csum", 32'(bus.ld_csum), 32'h0001);
      check("drop.done", 32'(bus.ld_done), 1);
      fetch("drop.f0", 6'd0, 1'b1, '{v: 1'b1, op: 16'h0001});
      fetch("drop.f1", 6'd1, 1'b1, '{v: 1'b1, op: FILL});

      // reset in the middle of a load
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
      beat(16'hAAAA, 1'b0);
      beat(16'hBBBB, 1'b0);
      check("mid.len2", 32'(bus.ld_len), 2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid.opv", 32'(bus.op_valid), 0);
      check("mid.len", 32'(bus.ld_len), 0);
      check("mid.ready", 32'(bus.ld_ready), 0);
      check("mid.csum", 32'(bus.ld_csum), 0);
      fetch("mid.f0", 6'd0, 1'b1, '{v: 1'b0, op: FILL});
      beat(16'h5555, 1'b1);
      check("mid.nobeat", 32'(bus.ld_len), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
